ledseq: RTL and testbench
=========================

LEDSEQ -- requirements
Module: ledseq

Interface
REQ-001 SHALL have parameter NLEDS, default 8, number of driven LEDs (1..8).
REQ-002 SHALL have port i_clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports i_wb_cyc, i_wb_stb, i_wb_we  input  1 each  Wishbone pipelined slave controls.
REQ-005 SHALL have port i_wb_addr  input  5  word address.
REQ-006 SHALL have ports i_wb_data  input  32  write data; i_wb_sel  input  4  byte enables.
REQ-007 SHALL have ports o_wb_stall  output  1  (constant 0); o_wb_ack  output  1; o_wb_data  output  32.
REQ-008 SHALL have port o_led  output  NLEDS  active-high LED pattern for the LED driver.
REQ-009 SHALL have port o_busy  output  1  high when state is not IDLE.
REQ-010 SHALL have port o_int  output  1  one-cycle completion pulse.

Function
REQ-011 SHALL accept a bus request when i_wb_cyc && i_wb_stb; o_wb_ack is asserted exactly one cycle later; o_wb_data is registered and valid with ack.
REQ-012 SHALL honour i_wb_sel per byte lane on every write; unselected bytes are unchanged.
REQ-013 SHALL decode addr 0 as CTRL: bit0 RUN, bit1 LOOP, bits[11:8] LAST (index of final step); readback: bit0 = o_busy, bit1 LOOP, [11:8] LAST, [19:16] current step, others 0.
REQ-014 SHALL decode addr 1 as PRESCALE, bits[23:0]; reads return it zero-extended.
REQ-015 SHALL decode addr 16..31 as table entries 0..15: bits[7:0] pattern, bits[23:16] duration D; reads return the stored entry; addrs 2..15 read 0, writes ignored.
REQ-016 SHALL implement states IDLE, LOAD, HOLD, DONE.
REQ-017 A CTRL write with sel[0]=1 and RUN=1 SHALL set step=0 and enter LOAD on the next cycle, from any state (restart).
REQ-018 A CTRL write with sel[0]=1 and RUN=0 SHALL enter IDLE next cycle; o_led keeps its value; no o_int.
REQ-019 LOAD SHALL last one cycle: o_led <= table[step][NLEDS-1:0], dcnt <= (D==0 ? 1 : D), pcnt <= PRESCALE, then HOLD.
REQ-020 In HOLD, a tick SHALL occur on cycles where pcnt==0 (pcnt reloads PRESCALE); otherwise pcnt decrements; tick period is PRESCALE+1 cycles.
REQ-021 On a tick with dcnt>1, dcnt SHALL decrement; with dcnt==1 the step ends.
REQ-022 At step end: if step>=LAST and LOOP=1, step<=0, LOAD; if step>=LAST and LOOP=0, DONE; else step<=step+1, LOAD.
REQ-023 Each step SHALL therefore span exactly D'*(PRESCALE+1)+1 cycles, D' = max(D,1).
REQ-024 DONE SHALL last one cycle, pulse o_int=1 for that cycle, then IDLE; o_led retains last pattern.
REQ-025 Table, LAST, LOOP and PRESCALE writes during a run SHALL be accepted and take effect at the next LOAD or step-end comparison.
REQ-026 A restart write coinciding with a step end SHALL take priority (step 0, LOAD, no o_int).

Reset
REQ-027 i_reset SHALL force state IDLE, RUN/LOOP/LAST/PRESCALE/step/dcnt/pcnt = 0, o_led=0, o_busy=0, o_int=0, o_wb_ack=0; table contents are not reset.
REQ-028 Reset mid-run SHALL abort without o_int; reset during a bus request suppresses its ack.

Verification
REQ-029 PRESCALE=0, entries 0..2 = {0x01,D=2},{0x02,D=1},{0x04,D=3}, CTRL=0x0201 -> o_led 0x01 for 3 cycles, 0x02 for 2, 0x04 for 4, then o_int 1 cycle, o_busy 0, o_led stays 0x04.
REQ-030 PRESCALE=3, entry0 {0xAA,D=0}, LAST=0, LOOP=1, RUN -> o_led 0xAA reloads every 5 cycles, never o_int; CTRL write 0 -> o_busy 0 next cycle, o_led 0xAA.
REQ-031 RUN write mid-step 2 of 4 -> next cycle LOAD, step 0 pattern one cycle later, no o_int.
REQ-032 Running LAST=5, write LAST=1 while at step 3 -> run ends after step 3, o_int pulses.
REQ-033 Write 0x12345678 with sel=0001 to entry 4, read back -> 0x00000078 (other bytes prior value); read addr 7 -> 0; every access acked exactly one cycle after stb.
REQ-034 i_reset asserted in HOLD -> next cycle o_led=0, o_busy=0, CTRL reads 0, no o_int.

Source files
------------

// File: rtl/ledseq.sv
// ledseq: Wishbone-programmable LED pattern sequencer with per-step durations
module ledseq #(
  parameter int NLEDS = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic [4:0]       i_wb_addr,
  input  logic [31:0]      i_wb_data,
  input  logic [3:0]       i_wb_sel,
  output logic             o_wb_stall,
  output logic             o_wb_ack,
  output logic [31:0]      o_wb_data,
  output logic [NLEDS-1:0] o_led,
  output logic             o_busy,
  output logic             o_int
);
  typedef enum logic [1:0] {IDLE, LOAD, HOLD, DONE} state_t;
  state_t state_q;
  logic loop_q, int_q, ack_q;
  logic [3:0] last_q, step_q;
  logic [23:0] pre_q, pcnt_q;
  logic [7:0] dcnt_q;
  logic [NLEDS-1:0] led_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] tbl_q [16];
  logic wr, wr_ctrl, wr_pre, go, stop, busy;
  logic [7:0] dur;
  assign wr = i_wb_cyc & i_wb_stb & i_wb_we;
  assign wr_ctrl = wr & (i_wb_addr == 5'd0);
  assign wr_pre = wr & (i_wb_addr == 5'd1);
  assign go = wr_ctrl & i_wb_sel[0] & i_wb_data[0];
  assign stop = wr_ctrl & i_wb_sel[0] & ~i_wb_data[0];
  assign busy = state_q != IDLE;
  assign dur = tbl_q[step_q][23:16];
  assign o_wb_stall = 1'b0;
  assign o_wb_ack = ack_q;
  assign o_wb_data = rdata_q;
  assign o_led = led_q;
  assign o_busy = busy;
  assign o_int = int_q;
  // Read mux sampled at request time; the register below makes it valid with ack.
  always_comb begin
    rdata_d = i_wb_addr == 5'd0 ? {12'd0, step_q, 4'd0, last_q, 6'd0, loop_q, busy}
            : i_wb_addr == 5'd1 ? {8'd0, pre_q}
            : i_wb_addr[4] ? tbl_q[i_wb_addr[3:0]]
            : 32'd0;
  end
  // Step table: byte-lane writes, deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++)
      if (wr && i_wb_addr[4] && i_wb_sel[b]) tbl_q[i_wb_addr[3:0]][8*b +: 8] <= i_wb_data[8*b +: 8];
  end
  // Bus response, config registers and the sequencer FSM; run/stop writes override stepping.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      loop_q <= 1'b0;
      last_q <= 4'd0;
      pre_q <= 24'd0;
      step_q <= 4'd0;
      dcnt_q <= 8'd0;
      pcnt_q <= 24'd0;
      led_q <= '0;
      int_q <= 1'b0;
      ack_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      ack_q <= i_wb_cyc & i_wb_stb;
      rdata_q <= rdata_d;
      int_q <= 1'b0;
      if (wr_ctrl && i_wb_sel[0]) loop_q <= i_wb_data[1];
      if (wr_ctrl && i_wb_sel[1]) last_q <= i_wb_data[11:8];
      for (int b = 0; b < 3; b++)
        if (wr_pre && i_wb_sel[b]) pre_q[8*b +: 8] <= i_wb_data[8*b +: 8];
      if (go) begin
        state_q <= LOAD;
        step_q <= 4'd0;
      end else if (stop) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          LOAD: begin
            led_q <= tbl_q[step_q][NLEDS-1:0];
            dcnt_q <= dur == 8'd0 ? 8'd1 : dur;
            pcnt_q <= pre_q;
            state_q <= HOLD;
          end
          HOLD: begin
            if (pcnt_q != 24'd0) begin
              pcnt_q <= pcnt_q - 24'd1;
            end else begin
              pcnt_q <= pre_q;
              if (dcnt_q > 8'd1) begin
                dcnt_q <= dcnt_q - 8'd1;
              end else if (step_q >= last_q) begin
                step_q <= loop_q ? 4'd0 : step_q;
                state_q <= loop_q ? LOAD : DONE;
                int_q <= ~loop_q;
              end else begin
                step_q <= step_q + 4'd1;
                state_q <= LOAD;
              end
            end
          end
          DONE: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ledseq.sv
// tb_ledseq: scoreboard bench for the LED sequencer and its bus interface
module tb_ledseq;
  logic clk = 1'b0;
  logic rst;
  logic cyc, stb, we;
  logic [4:0] addr;
  logic [31:0] wdat;
  logic [3:0] sel;
  logic stall, ack, busy, irq;
  logic [31:0] rdat;
  logic [7:0] led;
  logic req_q = 1'b0;
  logic [32:0] sb [$];
  int ntests = 0;
  int nfail = 0;

  ledseq #(.NLEDS(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdat), .i_wb_sel(sel), .o_wb_stall(stall),
    .o_wb_ack(ack), .o_wb_data(rdat), .o_led(led), .o_busy(busy), .o_int(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) req_q = cyc && stb && !rst;

  always @(negedge clk) begin
    logic [32:0] e;
    chk("ack", 32'(ack), 32'(req_q));
    if (ack) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e[32]) chk("rdata", rdat, e[31:0]);
      end
    end
  end

  task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input logic [31:0] exp);
    @(posedge clk);
    #1;
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdat = d; sel = s;
    sb.push_back({~w, exp});
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    bus(1'b1, a, d, s, 32'd0);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp);
    bus(1'b0, a, 32'd0, 4'hf, exp);
  endtask

  task automatic wait_led(input logic [7:0] v, input int lim);
    for (int i = 0; i < lim && led !== v; i++) @(negedge clk);
    chk("wait_led", 32'(led), 32'(v));
  endtask

  initial begin
    logic [7:0] pat [3];
    int dd [3];
    int span;
    logic seen_int, seen_next;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = 5'd0; wdat = 32'd0; sel = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_int", 32'(irq), 32'd0);
    chk("stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    rd(5'd0, 32'd0);
    rd(5'd1, 32'd0);

    // three-step single run, PRESCALE=0
    pat = '{8'h01, 8'h02, 8'h04};
    dd = '{2, 1, 3};
    wr(5'd1, 32'd0, 4'hf);
    for (int s = 0; s < 3; s++) wr(5'(16 + s), {8'd0, 8'(dd[s]), 8'd0, pat[s]}, 4'hf);
    wr(5'd0, 32'h0000_0201, 4'h3);
    @(negedge clk);
    chk("run_busy", 32'(busy), 32'd1);
    for (int s = 0; s < 3; s++) begin
      span = dd[s] * 1 + 1;
      for (int k = 0; k < span; k++) begin
        @(negedge clk);
        chk("seq_led", 32'(led), 32'(pat[s]));
        chk("seq_int", 32'(irq), 32'(s == 2 && k == span - 1));
      end
    end
    @(negedge clk);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_int", 32'(irq), 32'd0);
    chk("end_led", 32'(led), 32'h04);

    // looping single entry with D=0 and PRESCALE=3
    wr(5'd1, 32'd3, 4'hf);
    wr(5'd16, 32'h0000_00aa, 4'hf);
    wr(5'd0, 32'h0000_0003, 4'h3);
    wait_led(8'haa, 4);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("loop_led", 32'(led), 32'haa);
      chk("loop_int", 32'(irq), 32'd0);
      chk("loop_busy", 32'(busy), 32'd1);
    end
    wr(5'd16, 32'h0000_0055, 4'h1);
    wait_led(8'h55, 7);
    wr(5'd0, 32'd0, 4'h1);
    @(negedge clk);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_led", 32'(led), 32'h55);
    chk("stop_int", 32'(irq), 32'd0);

    // restart mid step 2 of 4
    wr(5'd1, 32'd1, 4'hf);
    for (int s = 0; s < 4; s++) wr(5'(16 + s), {16'h0003, 8'd0, 8'(8'h11 * (s + 1))}, 4'hf);
    wr(5'd0, 32'h0000_0301, 4'h3);
    wait_led(8'h33, 40);
    @(negedge clk);
    wr(5'd0, 32'h0000_0301, 4'h3);
    @(negedge clk);
    chk("rs_load_led", 32'(led), 32'h33);
    chk("rs_load_int", 32'(irq), 32'd0);
    @(negedge clk);
    chk("rs_step0_led", 32'(led), 32'h11);
    chk("rs_step0_int", 32'(irq), 32'd0);
    wr(5'd0, 32'd0, 4'h1);

    // shrink LAST while running at step 3
    for (int s = 0; s < 6; s++) wr(5'(16 + s), {16'h0002, 8'd0, 8'(8'h10 + s)}, 4'hf);
    wr(5'd0, 32'h0000_0501, 4'h3);
    wait_led(8'h13, 40);
    wr(5'd0, 32'h0000_0100, 4'h2);
    seen_int = 1'b0;
    seen_next = 1'b0;
    for (int i = 0; i < 20 && !seen_int; i++) begin
      @(negedge clk);
      if (led == 8'h14) seen_next = 1'b1;
      if (irq) seen_int = 1'b1;
    end
    chk("last_int", 32'(seen_int), 32'd1);
    chk("last_noadv", 32'(seen_next), 32'd0);
    chk("last_led", 32'(led), 32'h13);
    @(negedge clk);
    chk("last_idle", 32'(busy), 32'd0);

    // byte lanes and address decode
    rd(5'd0, 32'h0003_0100);
    wr(5'd20, 32'd0, 4'hf);
    wr(5'd20, 32'h1234_5678, 4'h1);
    rd(5'd20, 32'h0000_0078);
    wr(5'd20, 32'haabb_ccdd, 4'h4);
    rd(5'd20, 32'h00bb_0078);
    wr(5'd7, 32'hffff_ffff, 4'hf);
    rd(5'd7, 32'd0);
    wr(5'd1, 32'hffff_ffff, 4'hf);
    rd(5'd1, 32'h00ff_ffff);
    wr(5'd1, 32'h0000_0064, 4'hf);
    rd(5'd1, 32'h0000_0064);

    // reset in HOLD, with a read request in the same cycle
    wr(5'd0, 32'h0000_0001, 4'h3);
    repeat (3) @(negedge clk);
    chk("hold_busy", 32'(busy), 32'd1);
    chk("hold_led", 32'(led), 32'h10);
    @(posedge clk);
    #1;
    rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 5'd0;
    @(posedge clk);
    #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("rh_led", 32'(led), 32'd0);
    chk("rh_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("rh_int", 32'(irq), 32'd0);
      @(negedge clk);
    end
    rd(5'd0, 32'd0);
    rd(5'd1, 32'd0);
    rd(5'd16, 32'h0002_0010);
    repeat (2) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
